layer1_stream_out: RTL and testbench

- Downstream neighbour of the 3x3 conv / max-pool stage.
- After that stage finishes, this block reads the 32x32 layer-1 result memory (csel=1, 1024 words of 13-bit fixed point, 9.4 format).
- It streams the words out in address order over a valid/ready interface to the next consumer.
- It also reports the global maximum of layer 1 on completion.

---
 rtl/layer1_stream_out_pkg.sv | 16 +
 rtl/layer1_stream_out_skid_fifo.sv | 91 +++++++++
 rtl/layer1_stream_out.sv | 142 ++++++++++++++
 tb/tb_layer1_stream_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/layer1_stream_out_pkg.sv
// Shared constants and state encoding for the layer-1 readout stream.
package layer1_stream_out_pkg;

   localparam int unsigned L1_DATA_W = 13;
   localparam int unsigned L1_ADDR_W = 12;
   localparam int unsigned L1_WORDS  = 1024;
   localparam logic        CSEL_L1   = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } l1_state_t;

endpackage

// File: rtl/layer1_stream_out_skid_fifo.sv
// Shift-register skid FIFO of {addr, data, last}; entry 0 is the head, so the
// head fields come straight from flops.
module layer1_skid_fifo #(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned DATA_W = 13,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              push_last,
   input  logic              pop,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output logic [ADDR_W-1:0] head_addr,
   output logic              head_last,
   output logic [CNT_W-1:0]  count_c
);

   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_n;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_n;
   logic [DEPTH-1:0]             last_q, last_n;
   logic [DEPTH-1:0]             vld_q,  vld_n;
   logic                         pop_ok;
   logic [CNT_W-1:0]             wr_idx;

   assign pop_ok = pop & vld_q[0];

   // Valid bits are always contiguous from entry 0.
   always_comb begin
      count_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count_c = count_c + CNT_W'(vld_q[i]);
      end
   end

   assign wr_idx = count_c - CNT_W'(pop_ok);

   always_comb begin
      data_n = data_q;
      addr_n = addr_q;
      last_n = last_q;
      vld_n  = vld_q;
      if (pop_ok) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            data_n[i] = data_q[i+1];
            addr_n[i] = addr_q[i+1];
            last_n[i] = last_q[i+1];
            vld_n[i]  = vld_q[i+1];
         end
         data_n[DEPTH-1] = '0;
         addr_n[DEPTH-1] = '0;
         last_n[DEPTH-1] = 1'b0;
         vld_n[DEPTH-1]  = 1'b0;
      end
      // Write lands behind whatever survives this cycle's pop.
      if (push) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) == wr_idx) begin
               data_n[i] = push_data;
               addr_n[i] = push_addr;
               last_n[i] = push_last;
               vld_n[i]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         addr_q <= '0;
         last_q <= '0;
         vld_q  <= '0;
      end else begin
         data_q <= data_n;
         addr_q <= addr_n;
         last_q <= last_n;
         vld_q  <= vld_n;
      end
   end

   assign head_valid = vld_q[0];
   assign head_data  = data_q[0];
   assign head_addr  = addr_q[0];
   assign head_last  = last_q[0];

endmodule

// File: rtl/layer1_stream_out.sv
// Reads the layer-1 result bank in address order and streams it over valid/ready,
// reporting the pass maximum. Define LAYER1_ZERO_SKIP_EN to drop zero words.
module layer1_stream_out
   import layer1_stream_out_pkg::*;
#(
   parameter int unsigned NUM_WORDS  = L1_WORDS,
   parameter int unsigned DATA_W     = L1_DATA_W,
   parameter int unsigned ADDR_W     = L1_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   output logic              csel,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic [DATA_W-1:0] max_val
);

   localparam int unsigned PTR_W = $clog2(NUM_WORDS + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 2;
   localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   l1_state_t         state, state_nxt;
   logic [PTR_W-1:0]  ptr, ptr_nxt, issue_addr;
   logic              issue;
   logic [1:0]        inflight;
   logic              ret_v;
   logic [ADDR_W-1:0] ret_addr;
   logic              push, pop, credit_ok;
   logic [CNT_W-1:0]  fifo_count;
   logic [OCC_W-1:0]  occ;

   assign pop = out_valid & out_ready;

   // Entries held plus reads still in flight must fit in the FIFO.
   assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
   assign credit_ok = occ < OCC_W'(FIFO_DEPTH);

`ifdef LAYER1_ZERO_SKIP_EN
   assign push = ret_v & (cdata_rd != '0);
`else
   assign push = ret_v;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // The start edge itself issues address 0 so data is back two edges later.
   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      issue_addr = ptr;
      ptr_nxt    = ptr;
      unique case (state)
         IDLE: begin
            if (start) begin
               issue      = 1'b1;
               issue_addr = '0;
               ptr_nxt    = PTR_W'(1);
               state_nxt  = (NUM_WORDS == 1) ? DRAIN : READ;
            end
         end
         READ: begin
            if (credit_ok) begin
               issue   = 1'b1;
               ptr_nxt = ptr + PTR_W'(1);
               if (ptr == LAST_PTR) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight == '0 &&
                (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         csel     <= 1'b0;
         crd      <= 1'b0;
         caddr_rd <= '0;
         ptr      <= '0;
         ret_v    <= 1'b0;
         ret_addr <= '0;
         inflight <= '0;
         max_val  <= '0;
      end else begin
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == DONE);
         csel     <= (state_nxt != IDLE) ? CSEL_L1 : 1'b0;
         crd      <= issue;
         if (issue) caddr_rd <= ADDR_W'(issue_addr);
         ptr      <= ptr_nxt;
         ret_v    <= crd;
         ret_addr <= caddr_rd;
         inflight <= inflight + 2'(issue) - 2'(ret_v);
         if (state == IDLE && start)
            max_val <= '0;
         else if (ret_v && (cdata_rd > max_val))
            max_val <= cdata_rd;
      end
   end

   layer1_skid_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (cdata_rd),
      .push_addr  (ret_addr),
      .push_last  (ret_addr == LAST_ADDR),
      .pop        (pop),
      .head_valid (out_valid),
      .head_data  (out_data),
      .head_addr  (out_addr),
      .head_last  (out_last),
      .count_c    (fifo_count)
   );

endmodule

// File: tb/tb_layer1_stream_out.sv
// Directed bench for layer1_stream_out with a behavioural one-cycle-latency memory.
module tb_layer1_stream_out;

   localparam int NUM   = 1024;
   localparam int DEPTH = 3;
   localparam int DW    = 13;
   localparam int AW    = 12;
`ifdef LAYER1_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, out_ready;
   logic          busy, done, crd, csel, out_valid, out_last;
   logic [AW-1:0] caddr_rd, out_addr;
   logic [DW-1:0] cdata_rd, out_data, max_val;
   logic [DW-1:0] mem [NUM];
   int            checks = 0;
   int            errors = 0;
   bit            ab;

   always #5 clk = ~clk;

   always @(posedge clk) if (crd) cdata_rd <= mem[caddr_rd];

   layer1_stream_out dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .crd       (crd),
      .caddr_rd  (caddr_rd),
      .csel      (csel),
      .cdata_rd  (cdata_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .max_val   (max_val)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int next_nz(input int from);
      int a = from;
      if (SKIP) while (a < NUM && mem[a] == '0) a++;
      return a;
   endfunction

   // One pass; caller has already driven start=1 ahead of the next edge.
   task automatic run_pass(input int mode, input int stall_len, input int busy_start_at,
                           input int abort_at, input bit chk_lat, input bit start_on_done,
                           input logic [DW-1:0] exp_max, output bit aborted);
      int nxt, acc, issued, first_acc, last_acc, exp_cnt;
      bit fin, prev_stall;
      logic [DW-1:0] pd;
      logic [AW-1:0] pa;
      nxt = next_nz(0); acc = 0; issued = 0; first_acc = -1; last_acc = -1;
      fin = 1'b0; prev_stall = 1'b0; aborted = 1'b0; pd = '0; pa = '0;
      exp_cnt = 0;
      for (int a = 0; a < NUM; a++) if (!SKIP || mem[a] != '0) exp_cnt++;
      for (int cyc = 1; cyc <= 8000 && !fin && !aborted; cyc++) begin
         @(negedge clk);
         start = (cyc == busy_start_at);
         if (cyc == 1) begin
            check("start_busy", 32'(busy), 1);
            check("start_csel", 32'(csel), 1);
            check("start_crd", 32'(crd), 1);
            check("start_max_clr", 32'(max_val), 0);
         end
         if (cyc == 2) check("lat_valid_low", 32'(out_valid), 0);
         if (chk_lat && !SKIP && cyc == 3) check("lat_valid_high", 32'(out_valid), 1);
         out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc <= stall_len) out_ready = 1'b0;
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(pd));
            check("hold_addr", 32'(out_addr), 32'(pa));
         end
         if (crd) begin
            check("rd_addr", 32'(caddr_rd), 32'(issued));
            check("rd_csel", 32'(csel), 1);
            issued++;
            if (!SKIP) check("credit", 32'(issued - acc <= DEPTH), 1);
         end
         if (stall_len > 0 && cyc == stall_len) begin
            check("stall_reads", 32'(issued), 32'(DEPTH));
            check("stall_crd", 32'(crd), 0);
         end
         if (abort_at > 0 && acc == abort_at) begin
            reset = 1'b0;
            #1;
            check("abort_ctl", 32'({busy, done, crd, csel, out_valid, out_last}), 0);
            check("abort_caddr", 32'(caddr_rd), 0);
            check("abort_data", 32'(out_data), 0);
            check("abort_addr", 32'(out_addr), 0);
            check("abort_max", 32'(max_val), 0);
            aborted = 1'b1;
         end else begin
            if (done) begin
               check("done_empty", 32'(out_valid), 0);
               check("done_all", 32'(nxt), 32'(NUM));
               check("done_count", 32'(acc), 32'(exp_cnt));
               check("done_max", 32'(max_val), 32'(exp_max));
               check("done_busy", 32'(busy), 1);
               if (acc > 0) check("done_timing", 32'(cyc), 32'(last_acc + 1));
               if (chk_lat && !SKIP) check("no_bubble", 32'(last_acc - first_acc), 32'(NUM - 1));
               start = start_on_done;
               fin = 1'b1;
            end else if (out_valid && out_ready) begin
               check("word_addr", 32'(out_addr), 32'(nxt));
               check("word_data", 32'(out_data), (nxt < NUM) ? 32'(mem[nxt]) : 32'hFFFF_FFFF);
               check("word_last", 32'(out_last), 32'(nxt == NUM - 1));
               acc++;
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
               nxt = next_nz(nxt + 1);
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pa = out_addr;
         end
      end
      check("pass_ended", 32'(fin | aborted), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; out_ready = 1'b0;
      for (int a = 0; a < NUM; a++) mem[a] = DW'(a << 4);
      repeat (2) @(negedge clk);
      check("rst_ctl", 32'({busy, done, crd, csel, out_valid, out_last}), 0);
      check("rst_caddr", 32'(caddr_rd), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_addr", 32'(out_addr), 0);
      check("rst_max", 32'(max_val), 0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
`ifndef LAYER1_ZERO_SKIP_EN
      // Ramp, full rate; start held through DONE and the following idle cycle.
      start = 1'b1;
      run_pass(0, 0, 0, 0, 1'b1, 1'b1, 13'h1FF0, ab);
      @(negedge clk);
      check("post_done_busy", 32'(busy), 0);
      check("post_done_pulse", 32'(done), 0);
      check("post_done_csel", 32'(csel), 0);
      check("post_done_crd", 32'(crd), 0);
      mem[300] = 13'h1FFF;
      run_pass(1, 0, 100, 0, 1'b0, 1'b0, 13'h1FFF, ab);
      mem[300] = DW'(300 << 4);
      @(negedge clk);
      check("single_done", 32'(done), 0);
      check("idle_again", 32'(busy), 0);
      // Consumer stalled for 20 cycles.
      start = 1'b1;
      run_pass(0, 20, 0, 0, 1'b0, 1'b0, 13'h1FF0, ab);
      // Reset in the middle of a pass, then a clean full pass.
      @(negedge clk);
      start = 1'b1;
      run_pass(0, 0, 0, 500, 1'b0, 1'b0, 13'h1FF0, ab);
      check("aborted", 32'(ab), 1);
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done), 0);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      run_pass(0, 0, 0, 0, 1'b1, 1'b0, 13'h1FF0, ab);
`else
      for (int a = 0; a < NUM; a++) mem[a] = '0;
      mem[5]    = 13'h0030;
      mem[1023] = 13'h0010;
      start = 1'b1;
      run_pass(0, 0, 0, 0, 1'b0, 1'b0, 13'h0030, ab);
      @(negedge clk);
      mem[5]    = '0;
      mem[1023] = '0;
      start = 1'b1;
      run_pass(1, 0, 0, 0, 1'b0, 1'b0, 13'h0000, ab);
`endif
      @(negedge clk);
      check("final_idle", 32'(busy), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
